// File: rtl/mode_counter.sv
// mode_counter: mode-controlled up/down counter with programmable inclusive
// limit, synchronous load, and wrap/saturation/mode-change status outputs.
module mode_counter #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             sat,
  output logic             mode_chg
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       mode_q;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             sat_nxt;

  // Next count and status: load beats enable; disabled cycles hold and clear flags.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    sat_nxt   = 1'b0;
    if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      case (mode)
        2'b00: begin
          // count above a freshly lowered limit wraps just like count == limit
          if (count < limit) begin
            count_nxt = count + ONE;
          end else begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end
        end
        2'b01: begin
          if (count == '0 || count > limit) begin
            count_nxt = limit;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count - ONE;
          end
        end
        2'b10: begin
          count_nxt = (count < limit) ? count + ONE : limit;
          sat_nxt   = (count_nxt == limit);
        end
        default: begin
          if (count > limit) begin
            count_nxt = limit;
          end else if (count != '0) begin
            count_nxt = count - ONE;
          end else begin
            count_nxt = '0;
          end
          sat_nxt = (count_nxt == '0);
        end
      endcase
    end
  end

  // Registered state: reset overrides everything; mode history tracked every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= RST_VAL;
      tc       <= 1'b0;
      sat      <= 1'b0;
      mode_chg <= 1'b0;
      mode_q   <= mode;
    end else begin
      count    <= count_nxt;
      tc       <= tc_nxt;
      sat      <= sat_nxt;
      mode_chg <= (mode != mode_q);
      mode_q   <= mode;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed plus random stimulus for mode_counter (WIDTH=4),
// expected results queued at drive time and compared after each edge.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [3:0] limit, load_val;
  logic [3:0] count;
  logic       tc, sat, mode_chg;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] c;
    logic       tc;
    logic       sat;
    logic       mc;
    int         direct;  // plan-table count value, -1 when not given
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_cnt;
  logic [1:0] m_modeq;

  mode_counter #(.WIDTH(4), .RST_VAL(4'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .limit(limit),
    .load(load), .load_val(load_val), .count(count), .tc(tc),
    .sat(sat), .mode_chg(mode_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference written straight from the mode table.
  task automatic model_push(input int direct);
    exp_t e;
    e.tc = 1'b0; e.sat = 1'b0; e.mc = 1'b0; e.direct = direct;
    if (rst) begin
      m_cnt   = 4'd0;
      m_modeq = mode;
    end else begin
      e.mc    = (mode != m_modeq);
      m_modeq = mode;
      if (load) begin
        m_cnt = (load_val > limit) ? limit : load_val;
      end else if (en) begin
        if (mode == 2'd0) begin
          if (m_cnt >= limit) begin m_cnt = 4'd0; e.tc = 1'b1; end
          else m_cnt = m_cnt + 4'd1;
        end else if (mode == 2'd1) begin
          if (m_cnt == 4'd0 || m_cnt > limit) begin m_cnt = limit; e.tc = 1'b1; end
          else m_cnt = m_cnt - 4'd1;
        end else if (mode == 2'd2) begin
          if (m_cnt >= limit) m_cnt = limit;
          else m_cnt = m_cnt + 4'd1;
          e.sat = (m_cnt == limit);
        end else begin
          if (m_cnt > limit) m_cnt = limit;
          else if (m_cnt != 4'd0) m_cnt = m_cnt - 4'd1;
          e.sat = (m_cnt == 4'd0);
        end
      end
    end
    e.c = m_cnt;
    sb.push_back(e);
  endtask

  // One clock: queue expectation for current inputs, then check just after the edge.
  task automatic step(input string tag, input int direct);
    exp_t e;
    model_push(direct);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".count"}, count, e.c);
    chk({tag, ".tc"}, {3'b0, tc}, {3'b0, e.tc});
    chk({tag, ".sat"}, {3'b0, sat}, {3'b0, e.sat});
    chk({tag, ".mode_chg"}, {3'b0, mode_chg}, {3'b0, e.mc});
    if (e.direct >= 0) chk({tag, ".plan"}, count, 4'(e.direct));
  endtask

  task automatic drive(input logic r, input logic e_, input logic [1:0] m,
                       input logic [3:0] lim, input logic ld, input logic [3:0] lv);
    rst = r; en = e_; mode = m; limit = lim; load = ld; load_val = lv;
  endtask

  initial begin
    int up_seq [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int dn_seq [4]  = '{1, 0, 9, 8};
    int us_seq [4]  = '{4, 5, 5, 5};
    m_cnt = 4'd0; m_modeq = 2'd0;

    // reset state
    drive(1, 0, 2'd0, 4'd9, 0, 4'd0);
    step("reset", 0);

    // up-wrap 0..9 then back to 0
    drive(0, 1, 2'd0, 4'd9, 0, 4'd0);
    foreach (up_seq[i]) step("upwrap", up_seq[i]);

    // load 2 then down-wrap through 0 to limit
    drive(0, 1, 2'd0, 4'd9, 1, 4'd2);
    step("load2", 2);
    drive(0, 1, 2'd1, 4'd9, 0, 4'd0);
    foreach (dn_seq[i]) step("dnwrap", dn_seq[i]);

    // up-saturate at limit 5, then disable
    drive(0, 1, 2'd2, 4'd5, 1, 4'd3);
    step("load3", 3);
    drive(0, 1, 2'd2, 4'd5, 0, 4'd0);
    foreach (us_seq[i]) step("upsat", us_seq[i]);
    drive(0, 0, 2'd2, 4'd5, 0, 4'd0);
    step("en_off", 5);

    // limit lowered under the count
    drive(0, 1, 2'd0, 4'd9, 1, 4'd8);
    step("load8a", 8);
    drive(0, 1, 2'd0, 4'd4, 0, 4'd0);
    step("lowlim_up", 0);
    drive(0, 1, 2'd0, 4'd9, 1, 4'd8);
    step("load8b", 8);
    drive(0, 1, 2'd3, 4'd4, 0, 4'd0);
    step("lowlim_dnsat", 4);

    // down-saturate reaching 0
    drive(0, 1, 2'd3, 4'd4, 1, 4'd1);
    step("load1", 1);
    drive(0, 1, 2'd3, 4'd4, 0, 4'd0);
    step("dnsat0", 0);
    step("dnsat_hold", 0);

    // load clamp wins over enabled counting
    drive(0, 1, 2'd0, 4'd9, 1, 4'd12);
    step("load_clamp", 9);

    // reset mid-count, then resume down-wrap
    drive(0, 1, 2'd1, 4'd9, 1, 4'd6);
    step("load6", 6);
    drive(1, 1, 2'd1, 4'd9, 1, 4'd3);
    step("rst_mid", 0);
    drive(0, 1, 2'd1, 4'd9, 0, 4'd0);
    step("resume", 9);
    step("resume", 8);

    // limit 0 in wrap mode: tc every enabled cycle
    drive(0, 1, 2'd0, 4'd0, 0, 4'd0);
    step("lim0", 0);
    step("lim0", 0);

    // full range wrap at limit 15
    drive(0, 1, 2'd0, 4'd15, 1, 4'd15);
    step("load15", 15);
    drive(0, 1, 2'd0, 4'd15, 0, 4'd0);
    step("fullwrap", 0);

    // random mix against the reference
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      step("rand", -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Synthesizable mode-controlled up/down counter: the DUT whose `rst`, `mode` and `count` activity the team's counter monitor observes and logs.
- Four counting modes: wrap-up, wrap-down, saturate-up, saturate-down.
- Programmable modulo limit, synchronous load, enable, terminal-count / saturation / mode-change status for the monitor and scoreboard.

Parameters:
WIDTH, 8, width of count, limit and load value
RST_VAL, 0, value of count after reset (must be <= limit in use)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; when low, count holds
mode  input  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 down-saturate
limit  input  WIDTH  inclusive upper bound of count range [0, limit]
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  registered counter value
tc  output  1  one-cycle terminal-count pulse on wrap
sat  output  1  high while a saturating mode holds count at its bound
mode_chg  output  1  one-cycle pulse when mode differs from previous cycle

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. No asynchronous logic.
- Reset (rst=1 at a rising edge): count=RST_VAL, tc=0, sat=0, mode_chg=0, mode_q=mode.
  - rst overrides load and en, including mid-count and mid-saturation.
- Priority, evaluated per edge: rst > load > en > hold.
- Load: count <= min(load_val, limit); tc=0; sat=0. Applies regardless of en.
- Counting step (en=1, no load). Next count and flags, all registered, visible the cycle after the edge:
  - 00 up-wrap:
    - count < limit: count+1.
    - count == limit: 0, tc=1.
    - count > limit (limit lowered): 0, tc=1.
  - 01 down-wrap:
    - count > 0 and count <= limit: count-1.
    - count == 0: limit, tc=1.
    - count > limit: limit, tc=1.
  - 10 up-saturate:
    - count < limit: count+1.
    - otherwise: limit, sat=1.
    - tc never asserts.
  - 11 down-saturate:
    - count > limit: limit.
    - count > 0: count-1.
    - count == 0: 0, sat=1.
- sat is registered. It is 1 only when the post-edge count sits at the active bound in a saturating mode with en=1. Otherwise it clears on the next edge.
- tc is a single-cycle pulse. It deasserts on the next edge unless another wrap occurs (e.g. limit=0 in a wrap mode → tc high every enabled cycle, count stays 0).
- en=0 (no load): count holds; tc=0; sat=0.
- Mode change:
  - mode_q registers mode every non-reset edge.
  - mode_chg=1 for one cycle when mode != mode_q at an edge.
  - The new mode takes effect on that same edge.
- Arithmetic is WIDTH-bit unsigned; no carry output. limit = 2^WIDTH-1 gives natural full-range wrap.
- limit is sampled every cycle; no latching.

Test Plan:
- WIDTH=4, limit=9, mode=00, en=1 from reset, 12 cycles → count 0,1..9,0,1; tc high exactly the cycle count returns to 0; sat=0 throughout.
- limit=9, load=1 load_val=2, then mode=01 for 4 cycles → count 2,1,0,9,8; tc high with count=9; mode_chg pulses once at the 00→01 edge.
- limit=5, mode=10, load_val=3, 4 enabled cycles → 4,5,5,5; sat rises with the first count=5 and stays high. en=0 → count 5, sat=0.
- count=8 with limit=9, then limit changes to 4: mode=00 → next count 0 with tc=1; repeat with mode=11 → next count 4, sat=0.
- load=1, load_val=12, limit=9 → count=9. Same cycle en=1, mode=00 → load wins, no tc.
- Assert rst mid-count (count=6, mode=01, en=1) → next edge count=RST_VAL(0), tc/sat/mode_chg=0. Deassert → counting resumes down-wrap: 9,8.
